// File: rtl/user_macro_mux.sv
// user_macro_mux: fans the Caravel host Wishbone bus out to N_SLOTS user macros, bounds each
// transfer with a timeout, and muxes one slot onto the IO pads. USER_MACRO_MUX_IRQ_EN enables user_irq.
module user_macro_mux #(
    parameter int         N_SLOTS = 4,
    parameter logic [7:0] BASE_HI = 8'h30,
    parameter int         TIMEOUT = 255,
    parameter int         IO_W    = 38
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [3:0]              wbs_sel_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [N_SLOTS-1:0]      m_cyc_o,
    output logic [N_SLOTS-1:0]      m_stb_o,
    output logic                    m_we_o,
    output logic [19:0]             m_adr_o,
    output logic [31:0]             m_dat_o,
    output logic [3:0]              m_sel_o,
    input  logic [32*N_SLOTS-1:0]   m_dat_i,
    input  logic [N_SLOTS-1:0]      m_ack_i,
    input  logic [N_SLOTS-1:0]      m_irq_i,
    input  logic [IO_W*N_SLOTS-1:0] m_io_out,
    input  logic [IO_W*N_SLOTS-1:0] m_io_oeb,
    output logic [IO_W-1:0]         io_out,
    output logic [IO_W-1:0]         io_oeb,
    output logic [2:0]              user_irq
);
    localparam logic [3:0]  NSLOT4   = 4'(N_SLOTS);
    localparam logic [3:0]  CSR_IDX  = 4'hF;
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          slot_q, slot_d;
    logic [15:0]         timer_q, timer_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdat_q, rdat_d;
    logic                we_q, we_d;
    logic [19:0]         adr_q, adr_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [3:0]          sel_q, sel_d;
    logic [3:0]          owner_q, owner_d;
    logic [N_SLOTS-1:0]  enable_q, enable_d;
    logic [7:0]          to_cnt_q, to_cnt_d;
    logic [3:0]          last_to_q, last_to_d;

    logic                ack_sel, en_sel, req, hit;
    logic [3:0]          idx;
    logic [31:0]         rdat_sel, csr_rdat;
    logic [N_SLOTS-1:0]  stb_vec;

    assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign hit = (wbs_adr_i[31:24] == BASE_HI);
    assign idx = wbs_adr_i[23:20];

    // Per-slot selects: active slot during FWD, and enable bit of the slot being decoded.
    always_comb begin
        ack_sel  = 1'b0;
        rdat_sel = '0;
        en_sel   = 1'b0;
        stb_vec  = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (slot_q == 4'(s)) begin
                ack_sel  = m_ack_i[s];
                rdat_sel = m_dat_i[32*s +: 32];
            end
            if (idx == 4'(s)) en_sel = enable_q[s];
            stb_vec[s] = (state_q == FWD) && (slot_q == 4'(s));
        end
    end

    always_comb begin
        csr_rdat = '0;
        case (wbs_adr_i[3:2])
            2'd0:    csr_rdat[3:0] = owner_q;
            2'd1:    csr_rdat[N_SLOTS-1:0] = enable_q;
            2'd2:    csr_rdat[11:0] = {last_to_q, to_cnt_q};
            default: csr_rdat = 32'(N_SLOTS);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        timer_d   = timer_q;
        ack_d     = 1'b0;
        rdat_d    = rdat_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        owner_d   = owner_q;
        enable_d  = enable_q;
        to_cnt_d  = to_cnt_q;
        last_to_d = last_to_q;
        case (state_q)
            IDLE: if (req) begin
                we_d   = wbs_we_i;
                adr_d  = wbs_adr_i[19:0];
                wdat_d = wbs_dat_i;
                sel_d  = wbs_sel_i;
                if (hit && idx == CSR_IDX) begin
                    rdat_d  = csr_rdat;
                    ack_d   = 1'b1;
                    state_d = RESP;
                    if (wbs_we_i) begin
                        case (wbs_adr_i[3:2])
                            2'd0: if (wbs_sel_i[0]) owner_d = wbs_dat_i[3:0];
                            2'd1: for (int i = 0; i < N_SLOTS; i++)
                                      if (wbs_sel_i[i/8]) enable_d[i] = wbs_dat_i[i];
                            2'd2: begin
                                to_cnt_d  = 8'd0;
                                last_to_d = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end else if (hit && idx < NSLOT4 && en_sel) begin
                    // Timer holds the number of FWD cycles spent, including the current one.
                    slot_d  = idx;
                    timer_d = 16'd1;
                    state_d = FWD;
                end else begin
                    rdat_d  = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
            end
            FWD: begin
                if (ack_sel) begin
                    rdat_d  = rdat_sel;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (timer_q == TO_LIM) begin
                    rdat_d    = ERR_WORD;
                    ack_d     = 1'b1;
                    state_d   = RESP;
                    last_to_d = slot_q;
                    if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            timer_q   <= '0;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            owner_q   <= '0;
            enable_q  <= '1;
            to_cnt_q  <= '0;
            last_to_q <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            timer_q   <= timer_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            owner_q   <= owner_d;
            enable_q  <= enable_d;
            to_cnt_q  <= to_cnt_d;
            last_to_q <= last_to_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign m_cyc_o   = stb_vec;
    assign m_stb_o   = stb_vec;
    assign m_we_o    = we_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = wdat_q;
    assign m_sel_o   = sel_q;

    // An owner outside the populated slots parks the pads as inputs.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (owner_q == 4'(s)) begin
                io_out = m_io_out[IO_W*s +: IO_W];
                io_oeb = m_io_oeb[IO_W*s +: IO_W];
            end
        end
    end

`ifdef USER_MACRO_MUX_IRQ_EN
    logic irq_lvl_q, irq_lvl_d;

    always_comb irq_lvl_d = |(m_irq_i & enable_q);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_lvl_q <= 1'b0;
        else          irq_lvl_q <= irq_lvl_d;
    end

    assign user_irq = {1'b0, irq_lvl_q, (to_cnt_q != 8'd0)};
`else
    logic unused_irq;
    assign unused_irq = ^m_irq_i;
    assign user_irq   = 3'b000;
`endif

endmodule

// File: doc/user_macro_mux.md
# user_macro_mux

Wishbone interconnect and IO multiplexer that sits between the Caravel management Wishbone bus and up to N_SLOTS user macros inside the user project wrapper. It decodes host cycles into per-slot Wishbone ports, bounds every transfer with a timeout, and answers with an error word on timeout so the host bus never hangs. A CSR window selects which slot owns the chip IO pads and which slots are enabled.

## Interface
- N_SLOTS, 4, number of macro slots, 1..15
- BASE_HI, 8'h30, required value of wbs_adr_i[31:24]
- TIMEOUT, 255, FWD cycles before error response, 1..65535
- IO_W, 38, IO pad count

- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host Wishbone control
- wbs_adr_i  in  32  host address
- wbs_dat_i  in  32  host write data
- wbs_sel_i  in  4  byte selects
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  registered read data
- m_cyc_o, m_stb_o  out  N_SLOTS  per-slot strobes, one-hot or zero
- m_we_o  out  1  latched write enable, shared
- m_adr_o  out  20  latched wbs_adr_i[19:0], shared
- m_dat_o  out  32  latched write data, shared
- m_sel_o  out  4  latched byte selects, shared
- m_dat_i  in  32*N_SLOTS  slot read data, slot s at [32s+31:32s]
- m_ack_i  in  N_SLOTS  slot acknowledges
- m_irq_i  in  N_SLOTS  slot interrupt levels
- m_io_out, m_io_oeb  in  IO_W*N_SLOTS  slot pad drive/enable
- io_out, io_oeb  out  IO_W  pad drive/enable to wrapper
- user_irq  out  3  to management core

## Operation
- Decode: hit when wbs_adr_i[31:24]==BASE_HI; slot index s=wbs_adr_i[23:20]; s==4'hF is CSR; s>=N_SLOTS (and !=F) or miss is "unmapped".
- FSM IDLE/FWD/RESP. IDLE: on cyc&stb latch adr/dat/sel/we. Enabled slot -> FWD. CSR, unmapped, or disabled slot -> RESP.
- FWD: m_cyc_o[s]=m_stb_o[s]=1, 16-bit timer counts. m_ack_i[s] -> capture m_dat_i slot s, RESP. Timer==TIMEOUT without ack -> data 32'hDEAD_BEEF, TO_CNT++ (8-bit, saturating), LAST_TO=s, RESP. Ack and expiry in same cycle: ack wins.
- RESP: wbs_ack_o=1 exactly one cycle, then IDLE. Unmapped/disabled read returns 32'h0; writes dropped.
- CSR (offset adr[3:2]): 0 IO_OWNER[3:0] rw; 1 ENABLE[N_SLOTS-1:0] rw; 2 STATUS {LAST_TO[11:8], TO_CNT[7:0]} ro, any write clears both; 3 reads N_SLOTS, write ignored. Writes honour wbs_sel_i per byte.
- ENABLE sampled only at IDLE decode; clearing it mid-FWD does not abort the transfer.
- IO mux (combinational): io_out/io_oeb = slot IO_OWNER vectors; IO_OWNER>=N_SLOTS -> io_out=0, io_oeb=all ones.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, m_cyc_o=m_stb_o=0, m_we_o=0, m_adr_o/m_dat_o/m_sel_o=0, IO_OWNER=0, ENABLE=all ones, TO_CNT=0, LAST_TO=0, state IDLE, user_irq=0.
- CSR/unmapped: request sampled edge k, wbs_ack_o high cycle k+1.
- Slot: request at edge k, m_stb_o high from cycle k+1; m_ack_i sampled edge j, wbs_ack_o high cycle j+1 (2-cycle min).
- Timeout: ack at cycle k+TIMEOUT+1.
- Master must drop stb in cycle after ack; IDLE ignores cycles while ack high.
- wb_rst_i in any state: next edge IDLE, strobes low, no ack emitted.

## Configuration
- USER_MACRO_MUX_IRQ_EN defined: user_irq[0]=(TO_CNT!=0), cleared by STATUS write; user_irq[1]=|(m_irq_i & ENABLE), registered one cycle; user_irq[2]=0.
- Undefined: user_irq=3'b000 constant, m_irq_i unused, no irq flops.

## Test plan
- Write 0x3020_0010 data 0xA5A5_0001, slot 2 acks 3 cycles after strobe -> m_cyc_o=4'b0100, m_adr_o=0x00010, wbs_ack_o once, 5 cycles after request.
- Read slot 1 with m_ack_i held low, TIMEOUT=8 -> wbs_dat_o=0xDEAD_BEEF at cycle 9, STATUS=0x0000_0101.
- Write 0x30F0_0000=3 -> io_out equals slot 3 m_io_out; write 7 -> io_oeb all ones, io_out 0.
- Write ENABLE=4'b1110, read slot 0 -> no m_cyc_o, ack next cycle, data 0; read 0x4000_0000 -> same.
- Assert wb_rst_i mid-FWD -> strobes low next edge, no ack; subsequent CSR read IO_OWNER=0, ENABLE=4'hF.
- IRQ_EN build: timeout -> user_irq[0]=1; write STATUS -> 0 next cycle; m_irq_i[2]=1 with slot 2 enabled -> user_irq[1]=1 one cycle later.
